relu_maxpool2x2: RTL and testbench
==================================

RELU_MAXPOOL2X2 -- requirements
Module: relu_maxpool2x2

Interface
REQ-001 Parameter DATA_WIDTH, default 24: width of data_in and data_out.
REQ-002 Parameter IMG_WIDTH, default 28: feature-map columns per row; SHALL be even and >= 2.
REQ-003 Parameter IMG_HEIGHT, default 28: feature-map rows per frame; SHALL be even and >= 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  DATA_WIDTH  signed two's-complement feature-map sample, raster order (row-major).
REQ-007 valid_in  input  1  data_in is valid this cycle; may deassert for any number of cycles between samples.
REQ-008 data_out  output  DATA_WIDTH  pooled, ReLU-clamped sample, signed, always >= 0.
REQ-009 valid_out  output  1  single-cycle strobe: data_out is valid.
REQ-010 frame_end  output  1  single-cycle strobe, coincident with valid_out, for the last pooled sample of a frame.

Function
REQ-011 Input counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL advance only on cycles with valid_in=1.
REQ-012 col SHALL wrap to 0 after IMG_WIDTH-1 and increment row; row SHALL wrap to 0 after IMG_HEIGHT-1, starting the next frame without any idle cycle.
REQ-013 On even col, the sample SHALL be held in a pair register; on odd col, pair_max = signed max(held, data_in).
REQ-014 Even row: pair_max SHALL be written to line buffer entry col/2 (IMG_WIDTH/2 entries, DATA_WIDTH each); no output.
REQ-015 Odd row: pool = signed max(pair_max, line buffer entry col/2); out = (pool < 0) ? 0 : pool.
REQ-016 data_out/valid_out SHALL be registered: valid_out=1 exactly one cycle after the valid_in cycle carrying the odd-row, odd-col sample; 0 otherwise.
REQ-017 data_out SHALL hold its last value when valid_out=0.
REQ-018 frame_end SHALL be 1 only with the output produced by row=IMG_HEIGHT-1, col=IMG_WIDTH-1.
REQ-019 Comparisons SHALL be signed on the full DATA_WIDTH; no truncation, rounding or saturation; equal inputs yield that value.
REQ-020 Output rate: exactly (IMG_WIDTH/2)*(IMG_HEIGHT/2) strobes per frame; max one per clock.
REQ-021 Throughput: SHALL accept valid_in=1 every cycle indefinitely with no back-pressure.
REQ-022 Line-buffer read of entry k in an odd row and its write in the next frame's even row SHALL not conflict; data read SHALL always be from the preceding even row of the same frame.

Reset
REQ-023 rst=0 SHALL immediately clear col, row, pair register, valid_out, frame_end and data_out to 0.
REQ-024 Line-buffer contents need not be cleared; they SHALL never reach data_out before being rewritten in the current frame.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first valid_in after release is row 0, col 0.
REQ-026 A sample presented with valid_in=1 in the cycle rst deasserts SHALL be accepted as row 0, col 0.

Verification
REQ-027 IMG_WIDTH=4, IMG_HEIGHT=2, rows [1,5,-2,3] / [4,2,7,-9], valid_in every cycle -> outputs 5 then 7, each one cycle after its odd-col sample; frame_end with 7.
REQ-028 Same frame, all samples negative (-8,-3,-5,-1 / -2,-6,-7,-4) -> outputs 0 and 0; valid_out and frame_end timing unchanged.
REQ-029 Default 28x28 ramp frame (sample = row*28+col), random valid_in gaps -> 196 outputs, output (i,j) = (2i+1)*28+2j+1, frame_end only on 196th.
REQ-030 Two back-to-back 28x28 frames, second all -1 -> second frame yields 196 zeros; no first-frame values leak.
REQ-031 rst=0 asserted after 40 samples of a frame, then full frame -> valid_out/data_out 0 during reset; exactly 196 correct outputs afterward.
REQ-032 Max/min values: pair 0x7FFFFF vs 0x800000 (DATA_WIDTH=24) -> pooled output 0x7FFFFF; all-0x800000 window -> 0.

Source files
------------

// File: rtl/relu_maxpool2x2.sv
// ---------------------------------------------------------------------------
// relu_maxpool2x2
//   Streaming 2x2 max-pool with ReLU clamp for a raster-order feature map.
//   Samples arrive row-major, qualified by valid_in. Horizontal pairs are
//   reduced on the fly. The even-row pair maxima are parked in a line buffer
//   of IMG_WIDTH/2 entries. They are combined with the odd-row pair maxima
//   to form one pooled output per 2x2 window.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-low reset
//   data_in    : signed DATA_WIDTH sample
//   valid_in   : data_in qualifier; gaps of any length are allowed
//   data_out   : registered pooled sample, clamped to >= 0; holds when idle
//   valid_out  : one-cycle strobe, one clock after the odd-row/odd-col sample
//   frame_end  : one-cycle strobe with the last pooled sample of a frame
// ---------------------------------------------------------------------------
module relu_maxpool2x2 #(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_end
);

    localparam int CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] pair_q, pair_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  vout_q, vout_d;
    logic                  fe_q, fe_d;

    // Line buffer is intentionally not reset: an entry is always rewritten
    // in the even row before the odd row of the same frame reads it.
    logic [DATA_WIDTH-1:0] lb_q [LB_DEPTH];
    logic                  lb_we;
    logic [LW-1:0]         lb_idx;
    logic [DATA_WIDTH-1:0] lb_rd;

    logic                  col_last, row_last;
    logic [DATA_WIDTH-1:0] pair_max, pool, relu;

    assign col_last = (col_q == CW'(IMG_WIDTH - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
    assign lb_idx   = LW'(col_q >> 1);
    assign lb_rd    = lb_q[lb_idx];

    // All comparisons are full-width signed; ties pick either (same value).
    assign pair_max = ($signed(data_in) > $signed(pair_q)) ? data_in : pair_q;
    assign pool     = ($signed(pair_max) > $signed(lb_rd)) ? pair_max : lb_rd;
    assign relu     = pool[DATA_WIDTH-1] ? '0 : pool;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        pair_d = pair_q;
        dout_d = dout_q;
        vout_d = 1'b0;
        fe_d   = 1'b0;
        lb_we  = 1'b0;
        if (valid_in) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!col_q[0]) begin
                pair_d = data_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                vout_d = 1'b1;
                dout_d = relu;
                fe_d   = row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            pair_q <= '0;
            dout_q <= '0;
            vout_q <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            pair_q <= pair_d;
            dout_q <= dout_d;
            vout_q <= vout_d;
            fe_q   <= fe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) lb_q[lb_idx] <= pair_max;
    end

    assign data_out  = dout_q;
    assign valid_out = vout_q;
    assign frame_end = fe_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// ---------------------------------------------------------------------------
// tb_relu_maxpool2x2
//   Small 4x2 instance driven from a vector table (exact cycle timing, hold
//   behaviour, extreme values). Default 28x28 instance driven with generated
//   frames and random valid gaps, checked against a window-max model that
//   works on the whole frame image.
// ---------------------------------------------------------------------------
module tb_relu_maxpool2x2;

    localparam int DW = 24;
    localparam int W  = 28;
    localparam int H  = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // small 4x2 instance
    logic          s_rst = 1'b0;
    logic [DW-1:0] s_din = '0;
    logic          s_vin = 1'b0;
    logic [DW-1:0] s_dout;
    logic          s_vout, s_fe;

    relu_maxpool2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_s (
        .clk(clk), .rst(s_rst), .data_in(s_din), .valid_in(s_vin),
        .data_out(s_dout), .valid_out(s_vout), .frame_end(s_fe));

    // default 28x28 instance
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic          vin = 1'b0;
    logic [DW-1:0] dout;
    logic          vout, fe;

    relu_maxpool2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .data_in(din), .valid_in(vin),
        .data_out(dout), .valid_out(vout), .frame_end(fe));

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ev;
        logic [DW-1:0] ed;
        logic          ef;
    } vec_t;

    typedef struct {
        int d;
        bit fe;
    } exp_t;

    vec_t tv[$];
    exp_t expq[$];
    int   img[H][W];

    function automatic vec_t mk(logic v, int d, logic ev, int ed, logic ef);
        vec_t t;
        t.v  = v;
        t.d  = d[DW-1:0];
        t.ev = ev;
        t.ed = ed[DW-1:0];
        t.ef = ef;
        return t;
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Advance to the next falling edge and check the big instance's output
    // stream against the expectation queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst && vout) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid_out: data %h with no pending window", dout);
            end else begin
                e = expq.pop_front();
                chk("pool_data", dout, e.d[DW-1:0]);
                chk("pool_frame_end", {{(DW-1){1'b0}}, fe}, {{(DW-1){1'b0}}, e.fe});
            end
        end else if (fe) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_end_without_valid: frame_end 1 valid_out %b", vout);
        end
    endtask

    // Build a frame image, queue the windows completed within the first
    // nsamp samples, then stream those samples with random gaps.
    task automatic run_frame(input int kind, input int nsamp, input int gap_pct);
        logic signed [DW-1:0] r;
        int m, idx;
        exp_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                case (kind)
                    0: img[y][x] = y * W + x;
                    1: img[y][x] = -1;
                    default: begin
                        r = DW'($urandom);
                        img[y][x] = int'(r);
                    end
                endcase
            end
        for (int i = 0; i < H / 2; i++)
            for (int j = 0; j < W / 2; j++) begin
                if ((2 * i + 1) * W + 2 * j + 1 < nsamp) begin
                    m = img[2*i][2*j];
                    if (img[2*i][2*j+1] > m)   m = img[2*i][2*j+1];
                    if (img[2*i+1][2*j] > m)   m = img[2*i+1][2*j];
                    if (img[2*i+1][2*j+1] > m) m = img[2*i+1][2*j+1];
                    e.d  = (m < 0) ? 0 : m;
                    e.fe = (i == H / 2 - 1) && (j == W / 2 - 1);
                    expq.push_back(e);
                end
            end
        idx = 0;
        while (idx < nsamp) begin
            if ($urandom_range(99) < gap_pct) begin
                vin = 1'b0;
                din = DW'($urandom);
            end else begin
                vin = 1'b1;
                din = DW'(img[idx / W][idx % W]);
                idx++;
            end
            tick();
        end
        vin = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) tick();
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL missing_outputs: %0d windows never produced, required 0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        // small instance vector table
        tv.push_back(mk(1, 1, 0, 0, 0));
        tv.push_back(mk(1, 5, 0, 0, 0));
        tv.push_back(mk(1, -2, 0, 0, 0));
        tv.push_back(mk(1, 3, 0, 0, 0));
        tv.push_back(mk(1, 4, 0, 0, 0));
        tv.push_back(mk(1, 2, 1, 5, 0));
        tv.push_back(mk(1, 7, 0, 5, 0));
        tv.push_back(mk(1, -9, 1, 7, 1));
        tv.push_back(mk(0, 0, 0, 7, 0));
        tv.push_back(mk(1, -8, 0, 7, 0));
        tv.push_back(mk(1, -3, 0, 7, 0));
        tv.push_back(mk(1, -5, 0, 7, 0));
        tv.push_back(mk(1, -1, 0, 7, 0));
        tv.push_back(mk(1, -2, 0, 7, 0));
        tv.push_back(mk(1, -6, 1, 0, 0));
        tv.push_back(mk(1, -7, 0, 0, 0));
        tv.push_back(mk(1, -4, 1, 0, 1));
        tv.push_back(mk(1, 32'h007FFFFF, 0, 0, 0));
        tv.push_back(mk(0, 32'h00000123, 0, 0, 0));
        tv.push_back(mk(1, 32'h00800000, 0, 0, 0));
        tv.push_back(mk(1, 32'h00800000, 0, 0, 0));
        tv.push_back(mk(1, 32'h00800000, 0, 0, 0));
        tv.push_back(mk(1, 32'h00800000, 0, 0, 0));
        tv.push_back(mk(1, 32'h00800000, 1, 32'h007FFFFF, 0));
        tv.push_back(mk(0, 0, 0, 32'h007FFFFF, 0));
        tv.push_back(mk(1, 32'h00800000, 0, 32'h007FFFFF, 0));
        tv.push_back(mk(1, 32'h00800000, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0));

        // reset state of both instances
        #2;
        chk("rst_s_data", s_dout, '0);
        chk("rst_s_valid", {{(DW-1){1'b0}}, s_vout}, '0);
        chk("rst_s_fe", {{(DW-1){1'b0}}, s_fe}, '0);
        chk("rst_data", dout, '0);
        chk("rst_valid", {{(DW-1){1'b0}}, vout}, '0);
        @(negedge clk);
        s_rst = 1'b1;
        tick();

        foreach (tv[i]) begin
            s_vin = tv[i].v;
            s_din = tv[i].d;
            tick();
            chk($sformatf("tv%0d_valid", i), {{(DW-1){1'b0}}, s_vout}, {{(DW-1){1'b0}}, tv[i].ev});
            chk($sformatf("tv%0d_data", i), s_dout, tv[i].ed);
            chk($sformatf("tv%0d_fe", i), {{(DW-1){1'b0}}, s_fe}, {{(DW-1){1'b0}}, tv[i].ef});
        end

        // 28x28: first sample accepted in the release cycle
        rst = 1'b1;
        run_frame(0, W * H, 30);              // ramp, random gaps
        run_frame(1, W * H, 0);               // all -1, back-to-back, no gaps
        drain();
        run_frame(2, W * H, 20);              // random signed values
        drain();

        // mid-frame reset after 40 samples
        run_frame(2, 40, 10);
        tick();
        tick();
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL partial_frame_outputs: %0d pending, required 0", expq.size());
            expq.delete();
        end
        vin = 1'b1;
        din = DW'(32'h00055555);
        rst = 1'b0;
        #1;
        chk("midrst_data", dout, '0);
        chk("midrst_valid", {{(DW-1){1'b0}}, vout}, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("inrst_data", dout, '0);
            chk("inrst_valid", {{(DW-1){1'b0}}, vout}, '0);
        end
        rst = 1'b1;
        run_frame(2, W * H, 25);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
